cache_mem_arbiter: RTL and testbench
====================================

Name:
cache_mem_arbiter

Overview:
- Shares one memory val/rdy port between NUM_REQ cache controllers. Port 0 is the I-cache and port 1 is the D-cache.
- Grants the memory request channel to one cache at a time, round-robin.
- Holds the grant for a whole line transfer (evict or refill burst), so bursts never interleave.
- Routes in-order memory responses back to the originating cache using an ID-ordering FIFO.

Parameters:
- NUM_REQ, 2, number of requesting caches (≥2).
- REQ_W, 77, opaque memory request message width.
- RESP_W, 47, opaque memory response message width.
- LINE_WORDS, 16, maximum beats per grant.
- MAX_OUTSTANDING, 4, ID FIFO depth; a power of two.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- req_val  in  NUM_REQ  per-cache request valid
- req_rdy  out  NUM_REQ  per-cache request ready
- req_last  in  NUM_REQ  marks the final beat of the current transfer
- req_msg  in  NUM_REQ*REQ_W  packed requests; requester i occupies bits [i*REQ_W +: REQ_W]
- resp_val  out  NUM_REQ  per-cache response valid
- resp_rdy  in  NUM_REQ  per-cache response ready
- resp_msg  out  RESP_W  response message, broadcast to all caches
- mem_req_val  out  1  request valid to memory
- mem_req_rdy  in  1  memory accepts request
- mem_req_msg  out  REQ_W  granted requester's message
- mem_resp_val  in  1  memory response valid
- mem_resp_rdy  out  1  arbiter accepts response
- mem_resp_msg  in  RESP_W  memory response

Behaviour:
- Reset: synchronous, active-high.
  - State IDLE, grant register g=0, round-robin pointer ptr=0, beat_cnt=0, ID FIFO empty.
  - All req_rdy, resp_val, mem_req_val and mem_resp_rdy are 0 during reset and in the cycle after.
  - Reset mid-burst abandons the burst and empties the FIFO; outstanding responses are not tracked.
- State IDLE:
  - No request is accepted.
  - If any req_val: g <= first requester with req_val, scanning ptr, ptr+1, … mod NUM_REQ. beat_cnt <= 0. Next state LOCK.
  - Arbitration costs exactly 1 cycle.
- State LOCK, request channel:
  - mem_req_val = req_val[g] && !full.
  - mem_req_msg = slice g.
  - req_rdy[g] = mem_req_rdy && !full. All other req_rdy = 0.
- Fire = req_val[g] && req_rdy[g]. On fire:
  - push g into the FIFO;
  - beat_cnt <= beat_cnt+1.
- Release occurs on a fire where req_last[g]=1 or beat_cnt==LINE_WORDS-1.
  - On release: ptr <= (g+1) mod NUM_REQ; next state IDLE.
  - Release is forced at LINE_WORDS beats even without req_last.
- Requester drops req_val while in LOCK: grant is held and the arbiter waits. There is no timeout.
- full uses the registered count. A push when full is blocked even if a pop occurs in the same cycle. A pop and a push in the same cycle when not full keep count unchanged.
- Response channel (combinational, independent of state):
  - head = FIFO head ID.
  - resp_val[head] = mem_resp_val && !empty; all others 0.
  - mem_resp_rdy = !empty && resp_rdy[head].
  - Pop on mem_resp_val && mem_resp_rdy.
  - Back-to-back responses are supported: 1 response per cycle, 0-cycle latency.
- Response with FIFO empty: mem_resp_rdy=0; the response is stalled, never dropped.
- Memory must return responses in request order.
- Worst-case starvation: each requester is granted within (NUM_REQ-1) bursts.

Optional Feature:
- Macro: CACHE_MEM_ARB_PERF_CNT_EN.
- When defined, adds output stall_cnt (NUM_REQ*32).
  - Counter i increments each cycle where req_val[i]=1 and req_rdy[i]=0.
  - Counters wrap at 2^32 and clear on reset.
- When undefined, the port and counters are absent. All other behaviour is identical.

Decomposition:
- Package cache_arb_pkg:
  - arb_state_t enum {IDLE, LOCK};
  - ID_W = $clog2(NUM_REQ);
  - PTR_W = $clog2(MAX_OUTSTANDING).
- Sub-module arb_id_fifo (depth MAX_OUTSTANDING, width ID_W):
  - push/pop/full/empty/head;
  - count register of width PTR_W+1.

Test Plan:
- Reset, then req_val=2'b11 together -> cycle 1: no rdy; cycle 2: requester 0 granted; requester 1 granted only after req0's last beat.
- Requester 1 sends 16 beats without req_last -> forced release after beat 16; requester 0 waiting is granted 1 cycle later; ptr=0 afterward.
- Single write beat from req 0 with req_last=1, then req 1 -> 1-beat grant; mem_resp routed to resp_val=2'b01 then 2'b10 in order.
- Memory holds responses; 4 beats accepted -> 5th beat stalls (req_rdy=0) until one response pops, then resumes next cycle.
- resp_rdy[head]=0 while mem_resp_val=1 -> mem_resp_rdy=0, no pop; resp_rdy=1 -> pop; interleaved IDs remain correctly ordered.
- Reset asserted at beat 7 of a burst -> next cycle IDLE, FIFO empty, all outputs 0; PERF build: stall_cnt=0.

Source files
------------

// File: rtl/cache_arb_pkg.sv
// Shared types and sizing for the cache/memory arbiter.
// Holds the build-time sizes, the arbiter state enum and the round-robin pick helper.
// Optional build macro CACHE_MEM_ARB_PERF_CNT_EN (used by the top) adds stall counters.
package cache_arb_pkg;

    localparam int unsigned NUM_REQ         = 2;
    localparam int unsigned REQ_W           = 77;
    localparam int unsigned RESP_W          = 47;
    localparam int unsigned LINE_WORDS      = 16;
    localparam int unsigned MAX_OUTSTANDING = 4;

    localparam int unsigned ID_W   = $clog2(NUM_REQ);
    localparam int unsigned PTR_W  = $clog2(MAX_OUTSTANDING);
    localparam int unsigned BEAT_W = $clog2(LINE_WORDS);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // First requester with req set, scanning ptr, ptr+1, ... mod NUM_REQ.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                input logic [ID_W-1:0]    ptr);
        logic [ID_W-1:0] pick;
        int              idx;
        pick = ptr;
        // Walk from the farthest offset down so the nearest one to ptr wins.
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % int'(NUM_REQ);
            if (req[ID_W'(idx)]) begin
                pick = ID_W'(idx);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of requester IDs; one entry per accepted memory request beat.
// Ports:
//   clk, reset      clock, synchronous active-high reset (empties the FIFO)
//   push, push_id   enqueue push_id (ignored when full)
//   pop             dequeue head (ignored when empty)
//   full, empty     occupancy flags from the registered count
//   head            ID at the head of the FIFO
module arb_id_fifo
    import cache_arb_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic [ID_W-1:0] push_id,
    input  logic            pop,
    output logic            full,
    output logic            empty,
    output logic [ID_W-1:0] head
);

    localparam int unsigned DEPTH = MAX_OUTSTANDING;

    logic [ID_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; only entries behind the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_id;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one memory val/rdy port between NUM_REQ caches
// (port 0 = I-cache, port 1 = D-cache). A grant is held for a whole line
// transfer; responses are steered back using an in-order ID FIFO.
// Optional macro CACHE_MEM_ARB_PERF_CNT_EN adds per-requester stall counters.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   req_val/req_rdy/req_last/req_msg per-cache request channel (msg i at [i*REQ_W +: REQ_W])
//   resp_val/resp_rdy/resp_msg       per-cache response handshake, broadcast message
//   mem_req_val/rdy/msg              request channel to memory
//   mem_resp_val/rdy/msg             response channel from memory
//   stall_cnt (macro only)           32-bit counter per requester of val && !rdy cycles
module cache_mem_arbiter
    import cache_arb_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_val,
    output logic [NUM_REQ-1:0]       req_rdy,
    input  logic [NUM_REQ-1:0]       req_last,
    input  logic [NUM_REQ*REQ_W-1:0] req_msg,
    output logic [NUM_REQ-1:0]       resp_val,
    input  logic [NUM_REQ-1:0]       resp_rdy,
    output logic [RESP_W-1:0]        resp_msg,
    output logic                     mem_req_val,
    input  logic                     mem_req_rdy,
    output logic [REQ_W-1:0]         mem_req_msg,
    input  logic                     mem_resp_val,
    output logic                     mem_resp_rdy,
`ifdef CACHE_MEM_ARB_PERF_CNT_EN
    output logic [NUM_REQ*32-1:0]    stall_cnt,
`endif
    input  logic [RESP_W-1:0]        mem_resp_msg
);

    arb_state_t        state;
    arb_state_t        next_state;
    logic [ID_W-1:0]   grant;
    logic [ID_W-1:0]   ptr;
    logic [BEAT_W-1:0] beat_cnt;
    logic              full;
    logic              empty;
    logic [ID_W-1:0]   head;
    logic              fire;
    logic              last_beat;
    logic              pop;

    assign fire      = req_val[grant] && req_rdy[grant];
    assign last_beat = req_last[grant] || (beat_cnt == BEAT_W'(LINE_WORDS - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic: one arbitration cycle, then hold until the release beat.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (|req_val)          next_state = LOCK;
            LOCK:    if (fire && last_beat) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request-channel outputs; forced low while reset is asserted.
    always_comb begin
        req_rdy     = '0;
        mem_req_val = 1'b0;
        if (state == LOCK && !reset) begin
            req_rdy[grant] = mem_req_rdy && !full;
            mem_req_val    = req_val[grant] && !full;
        end
    end

    // Granted requester's message slice.
    always_comb begin
        mem_req_msg = req_msg[REQ_W-1:0];
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant == ID_W'(i)) mem_req_msg = req_msg[i*REQ_W +: REQ_W];
        end
    end

    // Grant, round-robin pointer and beat counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant    <= '0;
            ptr      <= '0;
            beat_cnt <= '0;
        end else if (state == IDLE && |req_val) begin
            grant    <= rr_pick(req_val, ptr);
            beat_cnt <= '0;
        end else if (fire) begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
            if (last_beat) ptr <= ID_W'((int'(grant) + 1) % int'(NUM_REQ));
        end
    end

    // Response steering: the FIFO head names the cache owning the next response.
    always_comb begin
        resp_val     = '0;
        mem_resp_rdy = 1'b0;
        if (!reset && !empty) begin
            resp_val[head] = mem_resp_val;
            mem_resp_rdy   = resp_rdy[head];
        end
    end

    assign resp_msg = mem_resp_msg;
    assign pop      = mem_resp_val && mem_resp_rdy;

    arb_id_fifo u_id_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fire),
        .push_id (grant),
        .pop     (pop),
        .full    (full),
        .empty   (empty),
        .head    (head)
    );

`ifdef CACHE_MEM_ARB_PERF_CNT_EN
    // Cycles each requester spends waiting with a valid request.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (req_val[i] && !req_rdy[i]) begin
                    stall_cnt[i*32 +: 32] <= stall_cnt[i*32 +: 32] + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter.
// Build with CACHE_MEM_ARB_PERF_CNT_EN defined to also check the stall counters.
module tb_cache_mem_arbiter;
    import cache_arb_pkg::*;

    logic                     clk;
    logic                     reset;
    logic [NUM_REQ-1:0]       req_val;
    logic [NUM_REQ-1:0]       req_rdy;
    logic [NUM_REQ-1:0]       req_last;
    logic [NUM_REQ*REQ_W-1:0] req_msg;
    logic [NUM_REQ-1:0]       resp_val;
    logic [NUM_REQ-1:0]       resp_rdy;
    logic [RESP_W-1:0]        resp_msg;
    logic                     mem_req_val;
    logic                     mem_req_rdy;
    logic [REQ_W-1:0]         mem_req_msg;
    logic                     mem_resp_val;
    logic                     mem_resp_rdy;
    logic [RESP_W-1:0]        mem_resp_msg;
`ifdef CACHE_MEM_ARB_PERF_CNT_EN
    logic [NUM_REQ*32-1:0]    stall_cnt;
`endif

    logic [REQ_W-1:0] msg [NUM_REQ];
    int checks = 0;
    int errors = 0;

    cache_mem_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req_val      (req_val),
        .req_rdy      (req_rdy),
        .req_last     (req_last),
        .req_msg      (req_msg),
        .resp_val     (resp_val),
        .resp_rdy     (resp_rdy),
        .resp_msg     (resp_msg),
        .mem_req_val  (mem_req_val),
        .mem_req_rdy  (mem_req_rdy),
        .mem_req_msg  (mem_req_msg),
        .mem_resp_val (mem_resp_val),
        .mem_resp_rdy (mem_resp_rdy),
`ifdef CACHE_MEM_ARB_PERF_CNT_EN
        .stall_cnt    (stall_cnt),
`endif
        .mem_resp_msg (mem_resp_msg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of the response channel with mem_resp_val/resp_rdy already driven.
    task automatic resp_step(input string tag, input logic [NUM_REQ-1:0] exp_val, input logic exp_rdy);
        #1;
        check({tag, "_resp_val"}, 128'(resp_val), 128'(exp_val));
        check({tag, "_mem_resp_rdy"}, 128'(mem_resp_rdy), 128'(exp_rdy));
        tick();
    endtask

    // Lone requester id sends n beats, last beat marked; starts and ends in IDLE.
    task automatic burst(input string tag, input int id, input int n);
        req_val  = NUM_REQ'(1) << id;
        req_last = '0;
        #1 check({tag, "_arb"}, 128'(req_rdy), 128'd0);
        tick();
        for (int b = 0; b < n; b++) begin
            if (b == n - 1) req_last = NUM_REQ'(1) << id;
            #1;
            check({tag, "_rdy"}, 128'(req_rdy), 128'(NUM_REQ'(1) << id));
            check({tag, "_msg"}, 128'(mem_req_msg), 128'(msg[id]));
            tick();
        end
        req_val  = '0;
        req_last = '0;
    endtask

    initial begin
        msg[0] = {13'h1abc, 32'hdeadbeef, 32'h01234567};
        msg[1] = {13'h0f0f, 32'hcafef00d, 32'h89abcdef};
        req_msg      = {msg[1], msg[0]};
        reset        = 1'b1;
        req_val      = 2'b11;
        req_last     = '0;
        resp_rdy     = 2'b11;
        mem_req_rdy  = 1'b1;
        mem_resp_val = 1'b1;
        mem_resp_msg = 47'h1234_5678_9abc;

        // Reset: everything quiet during reset and the cycle after.
        tick();
        #1;
        check("rst_req_rdy", 128'(req_rdy), 128'd0);
        check("rst_mem_req_val", 128'(mem_req_val), 128'd0);
        check("rst_resp_val", 128'(resp_val), 128'd0);
        check("rst_mem_resp_rdy", 128'(mem_resp_rdy), 128'd0);
        tick();
        reset = 1'b0;
        #1;
        check("post_rst_req_rdy", 128'(req_rdy), 128'd0);
        check("post_rst_mem_req_val", 128'(mem_req_val), 128'd0);
        check("post_rst_mem_resp_rdy", 128'(mem_resp_rdy), 128'd0);
        mem_resp_val = 1'b0;
        tick();

        // Both request: req0 wins (ptr=0), 2 beats; req1 follows after release.
        #1;
        check("t1_g0_rdy", 128'(req_rdy), 128'd1);
        check("t1_g0_val", 128'(mem_req_val), 128'd1);
        check("t1_g0_msg", 128'(mem_req_msg), 128'(msg[0]));
        tick();
        req_last = 2'b01;
        #1 check("t1_g0_beat2", 128'(req_rdy), 128'd1);
        tick();
        req_val  = 2'b10;
        req_last = 2'b10;
        #1 check("t1_idle", 128'(req_rdy), 128'd0);
        tick();
        #1;
        check("t1_g1_rdy", 128'(req_rdy), 128'd2);
        check("t1_g1_msg", 128'(mem_req_msg), 128'(msg[1]));
        tick();
        req_val      = '0;
        req_last     = '0;
        mem_resp_val = 1'b1;
        #1 check("t1_resp_msg", 128'(resp_msg), 128'(47'h1234_5678_9abc));
        resp_step("t1_r0", 2'b01, 1'b1);
        resp_step("t1_r1", 2'b01, 1'b1);
        resp_step("t1_r2", 2'b10, 1'b1);
        resp_step("t1_empty", 2'b00, 1'b0);

        // Req1 runs 16 beats without last: forced release, waiting req0 next.
        req_val = 2'b10;
        #1 check("t2_arb", 128'(req_rdy), 128'd0);
        tick();
        req_val = 2'b11;
        for (int b = 0; b < int'(LINE_WORDS); b++) begin
            #1;
            check("t2_beat_rdy", 128'(req_rdy), 128'd2);
            check("t2_beat_resp", 128'(resp_val), (b == 0) ? 128'd0 : 128'd2);
            tick();
        end
        #1;
        check("t2_rel_rdy", 128'(req_rdy), 128'd0);
        check("t2_rel_val", 128'(mem_req_val), 128'd0);
        check("t2_rel_resp", 128'(resp_val), 128'd2);
        tick();
        req_last = 2'b01;
        #1 check("t2_g0_rdy", 128'(req_rdy), 128'd1);
        tick();
        req_val  = '0;
        req_last = '0;
        resp_step("t2_r_last", 2'b01, 1'b1);
        resp_step("t2_empty", 2'b00, 1'b0);
        mem_resp_val = 1'b0;

        // Single-beat transfers from req0 then req1; responses routed in order.
        burst("t3_b0", 0, 1);
        burst("t3_b1", 1, 1);
        mem_resp_val = 1'b1;
        resp_step("t3_r0", 2'b01, 1'b1);
        resp_step("t3_r1", 2'b10, 1'b1);
        resp_step("t3_empty", 2'b00, 1'b0);
        mem_resp_val = 1'b0;

        // FIFO full after 4 beats; a same-cycle pop does not unblock the push.
        req_val = 2'b01;
        #1 check("t4_arb", 128'(req_rdy), 128'd0);
        tick();
        for (int b = 0; b < 4; b++) begin
            #1 check("t4_beat", 128'(req_rdy), 128'd1);
            tick();
        end
        for (int s = 0; s < 2; s++) begin
            #1;
            check("t4_full_rdy", 128'(req_rdy), 128'd0);
            check("t4_full_val", 128'(mem_req_val), 128'd0);
            tick();
        end
        mem_resp_val = 1'b1;
        #1;
        check("t4_pop_rdy", 128'(req_rdy), 128'd0);
        check("t4_pop_resp", 128'(resp_val), 128'd1);
        check("t4_pop_mrr", 128'(mem_resp_rdy), 128'd1);
        tick();
        mem_resp_val = 1'b0;
        req_last     = 2'b01;
        #1 check("t4_resume", 128'(req_rdy), 128'd1);
        tick();
        req_val      = '0;
        req_last     = '0;
        mem_resp_val = 1'b1;
        for (int r = 0; r < 4; r++) resp_step("t4_drain", 2'b01, 1'b1);
        resp_step("t4_empty", 2'b00, 1'b0);
        mem_resp_val = 1'b0;

        // Head not ready: no pop; interleaved IDs 1,0,1 stay ordered.
        burst("t5_b1", 1, 1);
        burst("t5_b0", 0, 1);
        burst("t5_b1b", 1, 1);
        mem_resp_val = 1'b1;
        resp_rdy = 2'b01;
        resp_step("t5_hold_a", 2'b10, 1'b0);
        resp_step("t5_hold_b", 2'b10, 1'b0);
        resp_rdy = 2'b11;
        resp_step("t5_pop1", 2'b10, 1'b1);
        resp_rdy = 2'b10;
        resp_step("t5_hold0", 2'b01, 1'b0);
        resp_rdy = 2'b11;
        resp_step("t5_pop0", 2'b01, 1'b1);
        resp_step("t5_pop1b", 2'b10, 1'b1);
        resp_step("t5_empty", 2'b00, 1'b0);

        // Reset at beat 7 of a burst abandons it and empties the FIFO.
        req_val = 2'b01;
        tick();
        for (int b = 0; b < 6; b++) tick();
        #1 check("t6_beat7_rdy", 128'(req_rdy), 128'd1);
        reset = 1'b1;
        #1;
        check("t6_rst_req_rdy", 128'(req_rdy), 128'd0);
        check("t6_rst_mem_req_val", 128'(mem_req_val), 128'd0);
        check("t6_rst_resp_val", 128'(resp_val), 128'd0);
        check("t6_rst_mem_resp_rdy", 128'(mem_resp_rdy), 128'd0);
        tick();
        reset = 1'b0;
        #1;
        check("t6_post_req_rdy", 128'(req_rdy), 128'd0);
        check("t6_post_mem_req_val", 128'(mem_req_val), 128'd0);
        check("t6_post_resp_val", 128'(resp_val), 128'd0);
        check("t6_post_mem_resp_rdy", 128'(mem_resp_rdy), 128'd0);
`ifdef CACHE_MEM_ARB_PERF_CNT_EN
        check("t6_stall_cnt", 128'(stall_cnt), 128'd0);
`endif
        tick();
        #1 check("t6_regrant", 128'(req_rdy), 128'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
